// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
//
// Snoop-side responder for a cached ACE master. It takes one AC snoop at a
// time and looks up the local tag/state array. It answers on CR and, when the
// response carries data, streams the cache line on CD one beat per two cycles.
// It then issues a single state-update pulse (invalidate / clean / share)
// back to the cache controller.
//
// Optional build macro: ACE_SNOOP_CNT_EN
//   defined   - saturating hit/miss counters on cnt_hit_o / cnt_miss_o
//   undefined - counter logic absent, both outputs tied to zero
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   ac_valid_i/ac_ready_o         snoop request handshake
//   ac_addr_i/ac_snoop_i/ac_prot_i  snoop address, type, protection
//   cr_valid_o/cr_ready_i/cr_resp_o snoop response {WU,IS,PD,Err,DT}
//   cd_valid_o/cd_ready_i         snoop data handshake
//   cd_data_o/cd_last_o           snoop data beat and final-beat flag
//   lk_req_o/lk_addr_o/lk_prot_o  tag lookup request, line address, prot
//   lk_rsp_valid_i/lk_hit_i/lk_dirty_i/lk_shared_i  lookup result
//   rd_en_o/rd_beat_o/rd_data_i   data array read (data one cycle after rd_en_o)
//   upd_valid_o/upd_inval_o/upd_clean_o/upd_share_o  cache state update
//   cnt_hit_o/cnt_miss_o          performance counters
module ace_snoop_responder #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBeats = 4,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ac_valid_i,
    output logic                         ac_ready_o,
    input  logic [AddrWidth-1:0]         ac_addr_i,
    input  logic [3:0]                   ac_snoop_i,
    input  logic [2:0]                   ac_prot_i,
    output logic                         cr_valid_o,
    input  logic                         cr_ready_i,
    output logic [4:0]                   cr_resp_o,
    output logic                         cd_valid_o,
    input  logic                         cd_ready_i,
    output logic [DataWidth-1:0]         cd_data_o,
    output logic                         cd_last_o,
    output logic                         lk_req_o,
    output logic [AddrWidth-1:0]         lk_addr_o,
    output logic [2:0]                   lk_prot_o,
    input  logic                         lk_rsp_valid_i,
    input  logic                         lk_hit_i,
    input  logic                         lk_dirty_i,
    input  logic                         lk_shared_i,
    output logic                         rd_en_o,
    output logic [$clog2(LineBeats)-1:0] rd_beat_o,
    input  logic [DataWidth-1:0]         rd_data_i,
    output logic                         upd_valid_o,
    output logic                         upd_inval_o,
    output logic                         upd_clean_o,
    output logic                         upd_share_o,
    output logic [CntWidth-1:0]          cnt_hit_o,
    output logic [CntWidth-1:0]          cnt_miss_o
);

    localparam int unsigned BeatW   = $clog2(LineBeats);
    localparam int unsigned OffBits = $clog2(DataWidth / 8 * LineBeats);
    localparam logic [AddrWidth-1:0] LineMask = {AddrWidth{1'b1}} << OffBits;
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(LineBeats - 1);

    localparam logic [3:0] SnReadOnce     = 4'b0000;
    localparam logic [3:0] SnReadShared   = 4'b0001;
    localparam logic [3:0] SnReadUnique   = 4'b0111;
    localparam logic [3:0] SnCleanInvalid = 4'b1001;
    localparam logic [3:0] SnMakeInvalid  = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_LK,
        SEND_CR,
        READ,
        SEND_CD,
        UPDATE
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [3:0]             snoop_q, snoop_d;
    logic [2:0]             prot_q, prot_d;
    logic [4:0]             crResp_q, crResp_d;
    logic                   updInval_q, updInval_d;
    logic                   updClean_q, updClean_d;
    logic                   updShare_q, updShare_d;
    logic [BeatW-1:0]       beat_q, beat_d;
    logic [DataWidth-1:0]   cdData_q, cdData_d;
    logic                   fresh_q, fresh_d;

    // Next-state and output decode. The response and the pending update are
    // both resolved at lookup time so later states only replay latched bits.
    // fresh_q marks the first SEND_CD cycle of a beat: the array data is live
    // on rd_data_i only in that cycle, so it is forwarded directly and also
    // captured to keep the beat stable while CD is stalled.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        snoop_d     = snoop_q;
        prot_d      = prot_q;
        crResp_d    = crResp_q;
        updInval_d  = updInval_q;
        updClean_d  = updClean_q;
        updShare_d  = updShare_q;
        beat_d      = beat_q;
        cdData_d    = cdData_q;
        fresh_d     = 1'b0;
        ac_ready_o  = 1'b0;
        lk_req_o    = 1'b0;
        cr_valid_o  = 1'b0;
        rd_en_o     = 1'b0;
        cd_valid_o  = 1'b0;
        upd_valid_o = 1'b0;
        upd_inval_o = 1'b0;
        upd_clean_o = 1'b0;
        upd_share_o = 1'b0;

        case (state_q)
            IDLE: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    addr_d  = ac_addr_i & LineMask;
                    snoop_d = ac_snoop_i;
                    prot_d  = ac_prot_i;
                    state_d = LOOKUP;
                end
            end

            LOOKUP: begin
                lk_req_o = 1'b1;
                state_d  = WAIT_LK;
            end

            WAIT_LK: begin
                if (lk_rsp_valid_i) begin
                    updInval_d = 1'b0;
                    updClean_d = 1'b0;
                    updShare_d = 1'b0;
                    // Bit order {WasUnique, IsShared, PassDirty, Error, DataTransfer}
                    case (snoop_q)
                        SnReadOnce: begin
                            crResp_d = {lk_hit_i & ~lk_shared_i, lk_hit_i, 1'b0, 1'b0, lk_hit_i};
                        end
                        SnReadShared: begin
                            crResp_d   = {lk_hit_i & ~lk_shared_i, lk_hit_i,
                                          lk_hit_i & lk_dirty_i, 1'b0, lk_hit_i};
                            updShare_d = lk_hit_i;
                            updClean_d = lk_hit_i & lk_dirty_i;
                        end
                        SnReadUnique: begin
                            crResp_d   = {lk_hit_i & ~lk_shared_i, 1'b0,
                                          lk_hit_i & lk_dirty_i, 1'b0, lk_hit_i};
                            updInval_d = lk_hit_i;
                        end
                        SnCleanInvalid: begin
                            crResp_d   = {lk_hit_i & ~lk_shared_i, 1'b0, lk_hit_i & lk_dirty_i,
                                          1'b0, lk_hit_i & lk_dirty_i};
                            updInval_d = lk_hit_i;
                        end
                        SnMakeInvalid: begin
                            crResp_d   = {lk_hit_i & ~lk_shared_i, 4'b0000};
                            updInval_d = lk_hit_i;
                        end
                        default: begin
                            crResp_d = 5'b00010;
                        end
                    endcase
                    state_d = SEND_CR;
                end
            end

            SEND_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) begin
                    if (crResp_q[0]) begin
                        beat_d  = '0;
                        state_d = READ;
                    end else begin
                        state_d = UPDATE;
                    end
                end
            end

            READ: begin
                rd_en_o = 1'b1;
                fresh_d = 1'b1;
                state_d = SEND_CD;
            end

            SEND_CD: begin
                cd_valid_o = 1'b1;
                if (fresh_q) begin
                    cdData_d = rd_data_i;
                end
                if (cd_ready_i) begin
                    if (beat_q == LastBeat) begin
                        state_d = UPDATE;
                    end else begin
                        beat_d  = beat_q + BeatW'(1);
                        state_d = READ;
                    end
                end
            end

            UPDATE: begin
                upd_valid_o = updInval_q | updClean_q | updShare_q;
                upd_inval_o = updInval_q;
                upd_clean_o = updClean_q;
                upd_share_o = updShare_q;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and holding registers; reset aborts any snoop in flight, so a
    // pending update is dropped rather than issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            snoop_q    <= '0;
            prot_q     <= '0;
            crResp_q   <= '0;
            updInval_q <= 1'b0;
            updClean_q <= 1'b0;
            updShare_q <= 1'b0;
            beat_q     <= '0;
            cdData_q   <= '0;
            fresh_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            snoop_q    <= snoop_d;
            prot_q     <= prot_d;
            crResp_q   <= crResp_d;
            updInval_q <= updInval_d;
            updClean_q <= updClean_d;
            updShare_q <= updShare_d;
            beat_q     <= beat_d;
            cdData_q   <= cdData_d;
            fresh_q    <= fresh_d;
        end
    end

    assign lk_addr_o = addr_q;
    assign lk_prot_o = prot_q;
    assign cr_resp_o = crResp_q;
    assign rd_beat_o = beat_q;
    assign cd_data_o = fresh_q ? rd_data_i : cdData_q;
    assign cd_last_o = (state_q == SEND_CD) && (beat_q == LastBeat);

`ifdef ACE_SNOOP_CNT_EN
    logic                lkDone;
    logic [CntWidth-1:0] cntHit_q, cntHit_d;
    logic [CntWidth-1:0] cntMiss_q, cntMiss_d;

    assign lkDone = (state_q == WAIT_LK) && lk_rsp_valid_i;

    // Every completed lookup is counted, including illegal snoop types;
    // both counters stick at all-ones instead of wrapping.
    always_comb begin
        cntHit_d  = cntHit_q;
        cntMiss_d = cntMiss_q;
        if (lkDone && lk_hit_i && (cntHit_q != '1)) begin
            cntHit_d = cntHit_q + CntWidth'(1);
        end
        if (lkDone && !lk_hit_i && (cntMiss_q != '1)) begin
            cntMiss_d = cntMiss_q + CntWidth'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntHit_q  <= '0;
            cntMiss_q <= '0;
        end else begin
            cntHit_q  <= cntHit_d;
            cntMiss_q <= cntMiss_d;
        end
    end

    assign cnt_hit_o  = cntHit_q;
    assign cnt_miss_o = cntMiss_q;
`else
    assign cnt_hit_o  = '0;
    assign cnt_miss_o = '0;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Testbench for ace_snoop_responder. Each snoop pushes its expected CR
// response, CD beats and state update onto queues. Monitors pop and compare
// them as the responder produces output. Small models stand in for the tag
// lookup and the data array. Counters are checked against the saturating
// expectation when ACE_SNOOP_CNT_EN is defined, and against zero otherwise.
`timescale 1ns/1ps
module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LB = 4;
    localparam int CW = 2;
    localparam int CntMax = (1 << CW) - 1;

    logic            clk_i;
    logic            rst_ni;
    logic            ac_valid_i;
    logic            ac_ready_o;
    logic [AW-1:0]   ac_addr_i;
    logic [3:0]      ac_snoop_i;
    logic [2:0]      ac_prot_i;
    logic            cr_valid_o;
    logic            cr_ready_i;
    logic [4:0]      cr_resp_o;
    logic            cd_valid_o;
    logic            cd_ready_i;
    logic [DW-1:0]   cd_data_o;
    logic            cd_last_o;
    logic            lk_req_o;
    logic [AW-1:0]   lk_addr_o;
    logic [2:0]      lk_prot_o;
    logic            lk_rsp_valid_i;
    logic            lk_hit_i;
    logic            lk_dirty_i;
    logic            lk_shared_i;
    logic            rd_en_o;
    logic [1:0]      rd_beat_o;
    logic [DW-1:0]   rd_data_i;
    logic            upd_valid_o;
    logic            upd_inval_o;
    logic            upd_clean_o;
    logic            upd_share_o;
    logic [CW-1:0]   cnt_hit_o;
    logic [CW-1:0]   cnt_miss_o;

    ace_snoop_responder #(
        .AddrWidth(AW), .DataWidth(DW), .LineBeats(LB), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .lk_req_o(lk_req_o), .lk_addr_o(lk_addr_o), .lk_prot_o(lk_prot_o),
        .lk_rsp_valid_i(lk_rsp_valid_i), .lk_hit_i(lk_hit_i), .lk_dirty_i(lk_dirty_i),
        .lk_shared_i(lk_shared_i),
        .rd_en_o(rd_en_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
        .upd_valid_o(upd_valid_o), .upd_inval_o(upd_inval_o), .upd_clean_o(upd_clean_o),
        .upd_share_o(upd_share_o),
        .cnt_hit_o(cnt_hit_o), .cnt_miss_o(cnt_miss_o)
    );

    int assertCount = 0;
    int failCount   = 0;

    logic [4:0]    expCr[$];
    logic [DW-1:0] expCdData[$];
    logic          expCdLast[$];
    logic [2:0]    expUpd[$];

    logic cfgHit, cfgDirty, cfgShared;
    int   cfgLkLat = 1;
    int   crStall  = 0;
    bit   cdToggle = 0;
    bit   spuriousLk = 0;
    logic lkValidModel;
    int   lkCnt;
    int   crCnt;
    int   cyc = 0;
    int   crHsCyc = 0;
    int   expHit = 0;
    int   expMiss = 0;

    logic          prevEn;
    logic [AW-1:0] prevAddr;
    logic [1:0]    prevBeat;

    assign lk_rsp_valid_i = lkValidModel | spuriousLk;
    assign lk_hit_i       = cfgHit;
    assign lk_dirty_i     = cfgDirty;
    assign lk_shared_i    = cfgShared;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        assertCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a, input int b);
        return {a[47:0] ^ 48'hC0FF_EE00_0000, 16'(b) ^ 16'hBE00};
    endfunction

    // Data array: word for the requested beat appears in the cycle after
    // rd_en_o, and random junk in every other cycle.
    initial begin
        rd_data_i = '0;
        forever begin
            @(posedge clk_i);
            prevEn   = rd_en_o;
            prevAddr = lk_addr_o;
            prevBeat = rd_beat_o;
            #1;
            rd_data_i = prevEn ? memWord(prevAddr, int'(prevBeat)) : {$urandom, $urandom};
        end
    end

    // Tag lookup: result valid cfgLkLat cycles after the request pulse.
    initial begin
        lkValidModel = 1'b0;
        lkCnt = 0;
        forever begin
            @(negedge clk_i);
            lkValidModel = 1'b0;
            if (!rst_ni) begin
                lkCnt = 0;
            end else if (lk_req_o) begin
                lkCnt = cfgLkLat;
            end else if (lkCnt != 0) begin
                lkCnt--;
                if (lkCnt == 0) lkValidModel = 1'b1;
            end
        end
    end

    // Ready drivers: CR held off for crStall cycles, CD optionally toggling.
    initial begin
        cr_ready_i = 1'b1;
        cd_ready_i = 1'b1;
        crCnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (cr_valid_o) begin
                if (crCnt < crStall) begin
                    cr_ready_i = 1'b0;
                    crCnt++;
                end else begin
                    cr_ready_i = 1'b1;
                end
            end else begin
                crCnt = 0;
                cr_ready_i = 1'b1;
            end
            if (cd_valid_o) cd_ready_i = cdToggle ? ~cd_ready_i : 1'b1;
        end
    end

    // Output monitors: compare against queue heads, pop on handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (cr_valid_o) begin
                    if (expCr.size() == 0) begin
                        checkOutput("crUnexpected", 64'd1, 64'd0);
                    end else begin
                        checkOutput("crResp", 64'(cr_resp_o), 64'(expCr[0]));
                        if (cr_ready_i) begin
                            void'(expCr.pop_front());
                            crHsCyc = cyc;
                        end
                    end
                end
                if (cd_valid_o) begin
                    checkOutput("cdAfterCr", 64'(expCr.size()), 64'd0);
                    if (expCdData.size() == 0) begin
                        checkOutput("cdUnexpected", 64'd1, 64'd0);
                    end else begin
                        checkOutput("cdData", cd_data_o, expCdData[0]);
                        checkOutput("cdLast", 64'(cd_last_o), 64'(expCdLast[0]));
                        if (cd_ready_i) begin
                            void'(expCdData.pop_front());
                            void'(expCdLast.pop_front());
                        end
                    end
                end
                if (upd_valid_o) begin
                    if (expUpd.size() == 0) begin
                        checkOutput("updUnexpected", 64'd1, 64'd0);
                    end else begin
                        checkOutput("updBits", 64'({upd_inval_o, upd_clean_o, upd_share_o}),
                                    64'(expUpd.pop_front()));
                    end
                end
            end
        end
    end

    task automatic checkCounters(input string tag);
`ifdef ACE_SNOOP_CNT_EN
        checkOutput({tag, "CntHit"}, 64'(cnt_hit_o), 64'(expHit));
        checkOutput({tag, "CntMiss"}, 64'(cnt_miss_o), 64'(expMiss));
`else
        checkOutput({tag, "CntHit"}, 64'(cnt_hit_o), 64'd0);
        checkOutput({tag, "CntMiss"}, 64'(cnt_miss_o), 64'd0);
`endif
    endtask

    // Issue one snoop and queue everything the responder should produce.
    task automatic applyStimulus(input logic [3:0] sn, input logic [AW-1:0] addr,
                                 input logic [2:0] prot, input logic h, input logic d,
                                 input logic s, input int lat, input logic [4:0] eResp,
                                 input logic [2:0] eUpd);
        logic [AW-1:0] aligned;
        aligned = addr & ~64'h1F;
        @(negedge clk_i);
        checkOutput("acReadyIdle", 64'(ac_ready_o), 64'd1);
        cfgHit = h;
        cfgDirty = d;
        cfgShared = s;
        cfgLkLat = lat;
        expCr.push_back(eResp);
        if (eResp[0]) begin
            for (int b = 0; b < LB; b++) begin
                expCdData.push_back(memWord(aligned, b));
                expCdLast.push_back(b == LB - 1);
            end
        end
        if (eUpd != 3'b000) expUpd.push_back(eUpd);
        if (h) begin
            if (expHit < CntMax) expHit++;
        end else begin
            if (expMiss < CntMax) expMiss++;
        end
        ac_valid_i = 1'b1;
        ac_addr_i  = addr;
        ac_snoop_i = sn;
        ac_prot_i  = prot;
        @(posedge clk_i);
        #1;
        ac_valid_i = 1'b0;
        ac_addr_i  = {$urandom, $urandom};
        ac_snoop_i = 4'($urandom);
        ac_prot_i  = 3'($urandom);
        checkOutput("lkReq", 64'(lk_req_o), 64'd1);
        checkOutput("lkAddr", lk_addr_o, aligned);
        checkOutput("lkProt", 64'(lk_prot_o), 64'(prot));
        checkOutput("acReadyBusy", 64'(ac_ready_o), 64'd0);
    endtask

    // Wait (bounded) for the responder to return to idle, then check leftovers.
    task automatic waitIdle(input bit checkLat);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_i);
            if (ac_ready_o) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("idleTimeout", 64'(done), 64'd1);
        if (checkLat) checkOutput("acReadyLat", 64'(cyc - crHsCyc), 64'd2);
        checkOutput("crLeft", 64'(expCr.size()), 64'd0);
        checkOutput("cdLeft", 64'(expCdData.size()), 64'd0);
        checkOutput("updLeft", 64'(expUpd.size()), 64'd0);
        checkCounters("idle");
        crStall  = 0;
        cdToggle = 0;
    endtask

    initial begin
        bit found;
        rst_ni     = 1'b0;
        ac_valid_i = 1'b0;
        ac_addr_i  = '0;
        ac_snoop_i = '0;
        ac_prot_i  = '0;
        cfgHit     = 1'b0;
        cfgDirty   = 1'b0;
        cfgShared  = 1'b0;

        repeat (2) @(negedge clk_i);
        checkOutput("rstValids", 64'({cr_valid_o, cd_valid_o, cd_last_o, upd_valid_o,
                                      lk_req_o, rd_en_o}), 64'd0);
        checkOutput("rstResp", 64'(cr_resp_o), 64'd0);
        checkOutput("rstCdData", cd_data_o, 64'd0);
        checkOutput("rstAcReady", 64'(ac_ready_o), 64'd1);
        checkCounters("rst");
        #2 rst_ni = 1'b1;

        $display("[TB] ReadShared hit dirty unique");
        applyStimulus(4'b0001, 64'h1000, 3'b001, 1, 1, 0, 1, 5'b11101, 3'b011);
        waitIdle(0);
        $display("[TB] ReadUnique miss");
        applyStimulus(4'b0111, 64'h2040, 3'b010, 0, 0, 0, 2, 5'b00000, 3'b000);
        waitIdle(1);
        $display("[TB] CleanInvalid hit clean shared");
        applyStimulus(4'b1001, 64'h3000, 3'b100, 1, 0, 1, 1, 5'b00000, 3'b100);
        waitIdle(1);
        $display("[TB] Illegal snoop types");
        applyStimulus(4'b0011, 64'h4000, 3'b000, 1, 1, 0, 1, 5'b00010, 3'b000);
        waitIdle(1);
        applyStimulus(4'b1111, 64'h4100, 3'b111, 0, 0, 0, 1, 5'b00010, 3'b000);
        waitIdle(1);

        $display("[TB] Lookup response while idle");
        @(negedge clk_i);
        cfgHit = 1'b1;
        spuriousLk = 1'b1;
        @(negedge clk_i);
        spuriousLk = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("spurAcReady", 64'(ac_ready_o), 64'd1);
        checkOutput("spurCrValid", 64'(cr_valid_o), 64'd0);
        checkCounters("spur");

        $display("[TB] ReadOnce hit with stalls");
        crStall  = 5;
        cdToggle = 1;
        applyStimulus(4'b0000, 64'h5008, 3'b011, 1, 0, 1, 1, 5'b01001, 3'b000);
        waitIdle(0);
        $display("[TB] MakeInvalid hit");
        applyStimulus(4'b1101, 64'h6000, 3'b000, 1, 1, 0, 3, 5'b10000, 3'b100);
        waitIdle(1);
        $display("[TB] ReadUnique hit dirty, unaligned address");
        cdToggle = 1;
        applyStimulus(4'b0111, 64'h2_3456_789F, 3'b101, 1, 1, 0, 2, 5'b10101, 3'b100);
        waitIdle(0);
        $display("[TB] CleanInvalid hit dirty");
        applyStimulus(4'b1001, 64'h7020, 3'b000, 1, 1, 0, 1, 5'b10101, 3'b100);
        waitIdle(0);
        $display("[TB] ReadOnce miss");
        applyStimulus(4'b0000, 64'h8000, 3'b000, 0, 1, 1, 1, 5'b00000, 3'b000);
        waitIdle(1);

        $display("[TB] Reset during beat 2");
        cdToggle = 1;
        applyStimulus(4'b0111, 64'h9000, 3'b010, 1, 1, 0, 1, 5'b10101, 3'b100);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (cd_valid_o && rd_beat_o == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("beat2Reached", 64'(found), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("asyncRstValids", 64'({cr_valid_o, cd_valid_o, cd_last_o, upd_valid_o,
                                           lk_req_o, rd_en_o}), 64'd0);
        checkOutput("asyncRstCdData", cd_data_o, 64'd0);
        checkOutput("asyncRstBeat", 64'(rd_beat_o), 64'd0);
        checkOutput("asyncRstResp", 64'(cr_resp_o), 64'd0);
        expCr.delete();
        expCdData.delete();
        expCdLast.delete();
        expUpd.delete();
        expHit  = 0;
        expMiss = 0;
        cdToggle = 0;
        repeat (2) @(negedge clk_i);
        checkOutput("inRstUpd", 64'(upd_valid_o), 64'd0);
        #2 rst_ni = 1'b1;
        checkCounters("postRst");

        $display("[TB] ReadShared hit clean unique after reset");
        applyStimulus(4'b0001, 64'hA000, 3'b001, 1, 0, 0, 1, 5'b11001, 3'b001);
        waitIdle(0);

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
